// File: rtl/alu_exec_unit.sv
// RV32I integer/jump/branch execution unit driving the ALU half of the CDB.
// Define ALU_PIPE2_EN to insert an operand register stage (latency 2 instead of 1).
module alu_exec_unit #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 6,
    parameter int ROB_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback_signal,
    input  logic [OP_W-1:0]   optype_from_rs,
    input  logic [ROB_W-1:0]  rd_from_rs,
    input  logic [DATA_W-1:0] pc_from_rs,
    input  logic [DATA_W-1:0] Vi_from_rs,
    input  logic [DATA_W-1:0] Vj_from_rs,
    input  logic [DATA_W-1:0] imm_from_rs,
    output logic              alu_has_result,
    output logic [ROB_W-1:0]  alias_to_cdb,
    output logic [DATA_W-1:0] result_to_cdb,
    output logic              is_jump_out,
    output logic              jump_taken,
    output logic [DATA_W-1:0] target_pc
);
    localparam logic [OP_W-1:0] OP_NOP   = 6'd0,  OP_LUI  = 6'd1,  OP_AUIPC = 6'd2,
                                OP_JAL   = 6'd3,  OP_JALR = 6'd4,  OP_BEQ   = 6'd5,
                                OP_BNE   = 6'd6,  OP_BLT  = 6'd7,  OP_BGE   = 6'd8,
                                OP_BLTU  = 6'd9,  OP_BGEU = 6'd10, OP_ADDI  = 6'd19,
                                OP_SLTI  = 6'd20, OP_SLTIU = 6'd21, OP_XORI = 6'd22,
                                OP_ORI   = 6'd23, OP_ANDI = 6'd24, OP_SLLI  = 6'd25,
                                OP_SRLI  = 6'd26, OP_SRAI = 6'd27, OP_ADD   = 6'd28,
                                OP_SUB   = 6'd29, OP_SLL  = 6'd30, OP_SLT   = 6'd31,
                                OP_SLTU  = 6'd32, OP_XOR  = 6'd33, OP_SRL   = 6'd34,
                                OP_SRA   = 6'd35, OP_OR   = 6'd36, OP_AND   = 6'd37;

    logic [OP_W-1:0]   ex_op;
    logic [ROB_W-1:0]  ex_rd;
    logic [DATA_W-1:0] ex_pc, ex_vi, ex_vj, ex_imm;

`ifdef ALU_PIPE2_EN
    logic              s1_valid;
    logic [OP_W-1:0]   s1_op;
    logic [ROB_W-1:0]  s1_rd;
    logic [DATA_W-1:0] s1_pc, s1_vi, s1_vj, s1_imm;

    always_ff @(posedge clk) begin
        if (rst || rollback_signal) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_NOP;
            s1_rd    <= '0;
            s1_pc    <= '0;
            s1_vi    <= '0;
            s1_vj    <= '0;
            s1_imm   <= '0;
        end else if (rdy) begin
            s1_valid <= (optype_from_rs != OP_NOP);
            s1_op    <= optype_from_rs;
            s1_rd    <= rd_from_rs;
            s1_pc    <= pc_from_rs;
            s1_vi    <= Vi_from_rs;
            s1_vj    <= Vj_from_rs;
            s1_imm   <= imm_from_rs;
        end
    end

    assign ex_op  = s1_valid ? s1_op : OP_NOP;
    assign ex_rd  = s1_rd;
    assign ex_pc  = s1_pc;
    assign ex_vi  = s1_vi;
    assign ex_vj  = s1_vj;
    assign ex_imm = s1_imm;
`else
    assign ex_op  = optype_from_rs;
    assign ex_rd  = rd_from_rs;
    assign ex_pc  = pc_from_rs;
    assign ex_vi  = Vi_from_rs;
    assign ex_vj  = Vj_from_rs;
    assign ex_imm = imm_from_rs;
`endif

    logic              ex_alu, ex_jump, ex_taken;
    logic [DATA_W-1:0] ex_res, ex_tgt, br_tgt, link;

    assign br_tgt = ex_pc + ex_imm;
    assign link   = ex_pc + 32'd4;

    // Loads, stores, NOP and unknown opcodes leave ex_alu low so nothing is broadcast.
    always_comb begin
        ex_alu   = 1'b1;
        ex_jump  = 1'b0;
        ex_taken = 1'b0;
        ex_res   = '0;
        ex_tgt   = '0;
        case (ex_op)
            OP_LUI:   ex_res = ex_imm;
            OP_AUIPC: ex_res = br_tgt;
            OP_ADDI:  ex_res = ex_vi + ex_imm;
            OP_SLTI:  ex_res = {31'd0, $signed(ex_vi) < $signed(ex_imm)};
            OP_SLTIU: ex_res = {31'd0, ex_vi < ex_imm};
            OP_XORI:  ex_res = ex_vi ^ ex_imm;
            OP_ORI:   ex_res = ex_vi | ex_imm;
            OP_ANDI:  ex_res = ex_vi & ex_imm;
            OP_SLLI:  ex_res = ex_vi << ex_imm[4:0];
            OP_SRLI:  ex_res = ex_vi >> ex_imm[4:0];
            OP_SRAI:  ex_res = $unsigned($signed(ex_vi) >>> ex_imm[4:0]);
            OP_ADD:   ex_res = ex_vi + ex_vj;
            OP_SUB:   ex_res = ex_vi - ex_vj;
            OP_SLL:   ex_res = ex_vi << ex_vj[4:0];
            OP_SLT:   ex_res = {31'd0, $signed(ex_vi) < $signed(ex_vj)};
            OP_SLTU:  ex_res = {31'd0, ex_vi < ex_vj};
            OP_XOR:   ex_res = ex_vi ^ ex_vj;
            OP_SRL:   ex_res = ex_vi >> ex_vj[4:0];
            OP_SRA:   ex_res = $unsigned($signed(ex_vi) >>> ex_vj[4:0]);
            OP_OR:    ex_res = ex_vi | ex_vj;
            OP_AND:   ex_res = ex_vi & ex_vj;
            OP_JAL: begin
                ex_jump = 1'b1; ex_taken = 1'b1; ex_res = link; ex_tgt = br_tgt;
            end
            OP_JALR: begin
                ex_jump  = 1'b1; ex_taken = 1'b1; ex_res = link;
                ex_tgt   = (ex_vi + ex_imm) & ~32'd1;
            end
            OP_BEQ:  begin ex_jump = 1'b1; ex_tgt = br_tgt; ex_taken = (ex_vi == ex_vj); end
            OP_BNE:  begin ex_jump = 1'b1; ex_tgt = br_tgt; ex_taken = (ex_vi != ex_vj); end
            OP_BLT:  begin ex_jump = 1'b1; ex_tgt = br_tgt; ex_taken = ($signed(ex_vi) <  $signed(ex_vj)); end
            OP_BGE:  begin ex_jump = 1'b1; ex_tgt = br_tgt; ex_taken = ($signed(ex_vi) >= $signed(ex_vj)); end
            OP_BLTU: begin ex_jump = 1'b1; ex_tgt = br_tgt; ex_taken = (ex_vi <  ex_vj); end
            OP_BGEU: begin ex_jump = 1'b1; ex_tgt = br_tgt; ex_taken = (ex_vi >= ex_vj); end
            default: ex_alu = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || rollback_signal) begin
            alu_has_result <= 1'b0;
            is_jump_out    <= 1'b0;
            jump_taken     <= 1'b0;
            alias_to_cdb   <= '0;
            result_to_cdb  <= '0;
            target_pc      <= '0;
        end else if (rdy) begin
            if (ex_alu) begin
                alu_has_result <= 1'b1;
                alias_to_cdb   <= ex_rd;
                result_to_cdb  <= ex_res;
                target_pc      <= ex_tgt;
                is_jump_out    <= ex_jump;
                jump_taken     <= ex_taken;
            end else begin
                alu_has_result <= 1'b0;
                is_jump_out    <= 1'b0;
                jump_taken     <= 1'b0;
            end
        end
    end
endmodule
